iter_divider: RTL and testbench

//   Multi-cycle iterative divider. The inverse of our pipelined multiply-add

---
 rtl/iter_divider.sv | 158 +++++++++++++++
 tb/tb_iter_divider.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned.
// A start accepted in IDLE runs WIDTH shift-subtract steps in RUN, then FIX
// applies the sign correction and publishes quotient/remainder with a
// one-cycle done pulse. Results are held until the next completion.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Operation context captured at the accepted start
    logic [WIDTH-1:0] q_sh;      // dividend magnitude, shifted out as quotient shifts in
    logic [WIDTH-1:0] b_mag;     // divisor magnitude
    logic [WIDTH-1:0] rem_acc;   // partial remainder
    logic [WIDTH-1:0] dvd_raw;   // original dividend, returned on divide-by-zero
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             dbz;

    // Magnitudes of the incoming operands (only negated in signed mode)
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             dvd_neg, dvs_neg;

    // One restoring step
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             sub_ok;

    // Sign-corrected results written at FIX
    logic [WIDTH-1:0] fix_q, fix_r;

    // Operand magnitudes and sign flags for capture
    always_comb begin
        dvd_neg = is_signed & dividend[WIDTH-1];
        dvs_neg = is_signed & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
        dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;
    end

    // Shift-subtract step: trial subtract the divisor from the shifted remainder
    always_comb begin
        rem_shift = {rem_acc, q_sh[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_mag};
        sub_ok    = (rem_shift >= {1'b0, b_mag});
    end

    // Sign fix-up; divide-by-zero overrides with all-ones / original dividend.
    // MIN / -1 falls out naturally: the negated magnitude wraps back to MIN.
    always_comb begin
        if (dbz) begin
            fix_q = '1;
            fix_r = dvd_raw;
        end else begin
            fix_q = neg_q ? (~q_sh + 1'b1) : q_sh;
            fix_r = neg_r ? (~rem_acc + 1'b1) : rem_acc;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST_STEP) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: busy for the whole RUN/FIX span
    always_comb begin
        busy = 1'b0;
        case (state)
            RUN, FIX: busy = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    // Datapath: capture, iterate, publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sh        <= '0;
            b_mag       <= '0;
            rem_acc     <= '0;
            dvd_raw     <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz         <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_sh    <= dvd_mag;
                        b_mag   <= dvs_mag;
                        rem_acc <= '0;
                        dvd_raw <= dividend;
                        cnt     <= '0;
                        neg_q   <= dvd_neg ^ dvs_neg;
                        neg_r   <= dvd_neg;
                        dbz     <= (divisor == '0);
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (sub_ok) begin
                        rem_acc <= rem_diff[WIDTH-1:0];
                        q_sh    <= {q_sh[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_acc <= rem_shift[WIDTH-1:0];
                        q_sh    <= {q_sh[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    quotient    <= fix_q;
                    remainder   <= fix_r;
                    div_by_zero <= dbz;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: directed corner cases plus random operands checked
// against an arithmetic reference model (64-bit signed / unsigned division).
module tb_iter_divider;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] held_q = '0;
    logic [W-1:0] held_r = '0;

    iter_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic in 64 bits; divide-by-zero handled first
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb;
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            sa = s ? longint'($signed(a)) : longint'({32'd0, a});
            sb = s ? longint'($signed(b)) : longint'({32'd0, b});
            q = W'(sa / sb);
            r = W'(sa % sb);
            z = 1'b0;
        end
    endtask

    // Drive a request (called #1 after an edge); returns after the accepting edge
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        start = 1'b1; dividend = a; divisor = b; is_signed = s;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    // Wait for done, checking latency, hold of old results and optional ignored start
    task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic s, input int pulse_at);
        logic [W-1:0] eq, er;
        logic ez;
        int k;
        model(a, b, s, eq, er, ez);
        k = 0;
        while (k < LAT + 8) begin
            if (k == pulse_at) begin
                start = 1'b1; dividend = 1; divisor = 1; is_signed = 1'b0;
            end
            @(posedge clk); #1;
            k++;
            if (k == pulse_at + 1) start = 1'b0;
            if (k == W / 2) check({tag, "_held_q"}, quotient, held_q);
            if (done) break;
        end
        check({tag, "_latency"}, k, LAT);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, ez);
        held_q = eq;
        held_r = er;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s);
        launch(a, b, s);
        finish_op(tag, a, b, s, -5);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, done, 1'b0);
        check({tag, "_r_held"}, remainder, held_r);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic rs;
        int seen;

        // Reset state
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op("u100_7", 100, 7, 1'b0);
        run_op("s_m7_2", -7, 2, 1'b1);
        run_op("s_7_m2", 7, -2, 1'b1);
        run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("u_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("s_5_0", 5, 0, 1'b1);
        run_op("u_5_0", 5, 0, 1'b0);
        run_op("u_9_3", 9, 3, 1'b0);
        run_op("s_0_m5", 0, -5, 1'b1);
        run_op("s_m3_10", -3, 10, 1'b1);
        run_op("s_m8_0", -8, 0, 1'b1);

        // Start during busy is ignored; start in the done cycle is accepted
        launch(100, 7, 1'b0);
        finish_op("ign_pulse", 100, 7, 1'b0, 9);
        check("done_cycle_done", done, 1'b1);
        launch(20, 6, 1'b0);
        finish_op("b2b", 20, 6, 1'b0, -5);
        @(posedge clk); #1;

        // Reset mid-operation abandons it
        launch(1000, 3, 1'b0);
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_q", quotient, 0);
        check("mid_rst_r", remainder, 0);
        check("mid_rst_dbz", div_by_zero, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        held_q = '0; held_r = '0;
        seen = 0;
        repeat (LAT + 5) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("no_done_after_rst", seen, 0);
        run_op("after_rst", 77, 5, 1'b0);

        // Random operands, biased toward corner values
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rb = 0;
                1: rb = $urandom_range(1, 15);
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                4: ra = $urandom_range(0, 100);
                default: ;
            endcase
            run_op("rand", ra, rb, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
